// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_block_dp slice.
// Pure definitions: no latency or flow control of its own.
package ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset zero-fill sequencer: walks init_addr 0..W-1, one word per cycle, busy for exactly W cycles.
// No backpressure: the user ports are simply locked out while busy is high.
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int W           = 128,
  parameter int A_N         = 7,
  parameter int INIT_ON_RST = 1
) (
  input  logic           CLK,
  input  logic           RST_n,
  output logic           busy,
  output logic           init_we,
  output logic [A_N-1:0] init_addr
);

  localparam state_e         RST_STATE = (INIT_ON_RST != 0) ? ST_INIT : ST_READY;
  localparam logic           RST_BUSY  = (INIT_ON_RST != 0);
  localparam logic [A_N-1:0] LAST_ADDR = A_N'(W - 1);

  state_e         state_q, state_d;
  logic [A_N-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + A_N'(1);
        // Last word written this cycle: leave INIT and drop busy on the same edge.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        busy_d = 1'b0;
      end
      default: begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      busy_q  <= RST_BUSY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign init_we   = busy_q;
  assign init_addr = cnt_q;

endmodule

// File: rtl/ram_block_dp.sv
// Simple-dual-port RAM with byte-lane writes, RD_LAT (1|2) read latency, selectable read-during-write result.
// No backpressure: one read result per cycle when streaming; requests are dropped while zero-fill is busy.
module ram_block_dp
  import ram_pkg::*;
#(
  parameter int W           = 128,
  parameter int N           = 8,
  parameter int A_N         = 7,
  parameter int BE_N        = N / 8,
  parameter int RD_LAT      = 1,
  parameter int RDW_MODE    = 0,
  parameter int INIT_ON_RST = 1
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            wr,
  input  logic [A_N-1:0]  addr_w,
  input  logic [N-1:0]    data_i,
  input  logic [BE_N-1:0] be,
  input  logic            rd,
  input  logic [A_N-1:0]  addr_r,
  input  logic            oe,
  output logic [N-1:0]    data_o,
  output logic            rd_valid,
  output logic            busy
);

  localparam logic [A_N:0] W_LIM = (A_N + 1)'(W);

  logic           init_we;
  logic [A_N-1:0] init_addr;

  ram_init_seq #(
    .W           (W),
    .A_N         (A_N),
    .INIT_ON_RST (INIT_ON_RST)
  ) u_init_seq (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic [N-1:0] mem_q [W];

  logic            wr_in_range, rd_in_range;
  logic            user_we, rd_fire;
  logic            mem_we;
  logic [A_N-1:0]  mem_addr;
  logic [N-1:0]    mem_dat;
  logic [BE_N-1:0] mem_be;
  logic [N-1:0]    rd_word;

  assign wr_in_range = {1'b0, addr_w} < W_LIM;
  assign rd_in_range = {1'b0, addr_r} < W_LIM;
  assign user_we     = wr && !busy && wr_in_range;
  assign rd_fire     = rd && !busy;

  // The zero-fill owns the write port while it runs.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = addr_w;
    mem_dat  = data_i;
    mem_be   = be;
    if (init_we) begin
      mem_we   = 1'b1;
      mem_addr = init_addr;
      mem_dat  = '0;
      mem_be   = '1;
    end else if (user_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int k = 0; k < BE_N; k++) begin
        if (mem_be[k]) mem_q[mem_addr][8*k +: 8] <= mem_dat[8*k +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[addr_r];
    // Write-first: overlay the lanes being written on this same edge.
    if ((RDW_MODE == RDW_NEW) && user_we && (addr_w == addr_r)) begin
      for (int k = 0; k < BE_N; k++) begin
        if (be[k]) rd_word[8*k +: 8] = data_i[8*k +: 8];
      end
    end
  end

  logic         stage_vld;
  logic [N-1:0] stage_dat;

  if (RD_LAT == 2) begin : g_lat2
    logic         p1_vld_q, p1_vld_d;
    logic [N-1:0] p1_dat_q, p1_dat_d;

    always_comb begin
      p1_vld_d = rd_fire;
      p1_dat_d = rd_fire ? rd_word : p1_dat_q;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        p1_vld_q <= 1'b0;
        p1_dat_q <= '0;
      end else begin
        p1_vld_q <= p1_vld_d;
        p1_dat_q <= p1_dat_d;
      end
    end

    assign stage_vld = p1_vld_q;
    assign stage_dat = p1_dat_q;
  end else begin : g_lat1
    assign stage_vld = rd_fire;
    assign stage_dat = rd_word;
  end

  logic         rd_valid_q, rd_valid_d;
  logic [N-1:0] data_q, data_d;

  always_comb begin
    rd_valid_d = stage_vld;
    data_d     = stage_vld ? stage_dat : data_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rd_valid_q <= 1'b0;
      data_q     <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      data_q     <= data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign data_o   = oe ? '0 : data_q;

endmodule

// File: tb/tb_ram_block_dp.sv
// Directed bench for ram_block_dp: five instances cover the parameter corners.
module tb_ram_block_dp;

  localparam int AW = ram_pkg::clog2(128);

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr_w = '0;
  logic [7:0]    data_i = '0;
  logic [0:0]    be1 = 1'b1;
  logic [31:0]   data32 = '0;
  logic [3:0]    be4 = '0;
  logic          rd = 1'b0;
  logic [AW-1:0] addr_r = '0;
  logic          oe = 1'b0;

  logic [7:0]  d0, d2, d3, d4;
  logic [31:0] d1;
  logic        v0, v1, v2, v3, v4;
  logic        b0, b1, b2, b3, b4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  // u0: default config (RD_LAT=1, old-data RDW, W=128)
  ram_block_dp #(.W(128), .N(8), .A_N(7), .RD_LAT(1), .RDW_MODE(0), .INIT_ON_RST(1)) u0 (
    .CLK(CLK), .RST_n(RST_n), .wr(wr), .addr_w(addr_w), .data_i(data_i), .be(be1),
    .rd(rd), .addr_r(addr_r), .oe(oe), .data_o(d0), .rd_valid(v0), .busy(b0));
  // u1: 32-bit word, four byte lanes
  ram_block_dp #(.W(128), .N(32), .A_N(7), .RD_LAT(1), .RDW_MODE(0), .INIT_ON_RST(1)) u1 (
    .CLK(CLK), .RST_n(RST_n), .wr(wr), .addr_w(addr_w), .data_i(data32), .be(be4),
    .rd(rd), .addr_r(addr_r), .oe(oe), .data_o(d1), .rd_valid(v1), .busy(b1));
  // u2: write-first read-during-write
  ram_block_dp #(.W(128), .N(8), .A_N(7), .RD_LAT(1), .RDW_MODE(1), .INIT_ON_RST(1)) u2 (
    .CLK(CLK), .RST_n(RST_n), .wr(wr), .addr_w(addr_w), .data_i(data_i), .be(be1),
    .rd(rd), .addr_r(addr_r), .oe(oe), .data_o(d2), .rd_valid(v2), .busy(b2));
  // u3: two-cycle read latency
  ram_block_dp #(.W(128), .N(8), .A_N(7), .RD_LAT(2), .RDW_MODE(0), .INIT_ON_RST(1)) u3 (
    .CLK(CLK), .RST_n(RST_n), .wr(wr), .addr_w(addr_w), .data_i(data_i), .be(be1),
    .rd(rd), .addr_r(addr_r), .oe(oe), .data_o(d3), .rd_valid(v3), .busy(b3));
  // u4: W=100 leaves addresses 100..127 out of range
  ram_block_dp #(.W(100), .N(8), .A_N(7), .RD_LAT(1), .RDW_MODE(0), .INIT_ON_RST(1)) u4 (
    .CLK(CLK), .RST_n(RST_n), .wr(wr), .addr_w(addr_w), .data_i(data_i), .be(be1),
    .rd(rd), .addr_r(addr_r), .oe(oe), .data_o(d4), .rd_valid(v4), .busy(b4));

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (b0 !== 1'b1)  begin n_fail++; $display("FAIL reset_busy: got %b expected 1", b0); end
    n_checks++; if (v0 !== 1'b0)  begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", v0); end
    n_checks++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL reset_data_o: got %h expected 00", d0); end
  endtask

  task automatic test_zero_fill;
    int cnt;
    int cyc;
    logic saw_v;
    cnt = 0; cyc = 0; saw_v = 1'b0;
    @(posedge CLK); #1;
    RST_n = 1'b1;
    wr = 1'b1; addr_w = 7'd5; data_i = 8'hFF; be1 = 1'b1;
    rd = 1'b1; addr_r = 7'd5;
    while (b0 === 1'b1 && cyc < 200) begin
      cnt++;
      if (v0 !== 1'b0) saw_v = 1'b1;
      if (cyc == 10) begin wr = 1'b0; rd = 1'b0; end
      tick;
      cyc++;
    end
    wr = 1'b0; rd = 1'b0;
    n_checks++; if (cnt != 128) begin n_fail++; $display("FAIL zero_fill_busy_cycles: got %0d expected 128", cnt); end
    n_checks++; if (saw_v !== 1'b0) begin n_fail++; $display("FAIL init_no_rd_valid: got %b expected 0", saw_v); end
    rd = 1'b1; addr_r = 7'd5;
    tick;
    rd = 1'b0;
    n_checks++; if (v0 !== 1'b1)  begin n_fail++; $display("FAIL zero_fill_rd_valid: got %b expected 1", v0); end
    n_checks++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL zero_fill_addr5: got %h expected 00", d0); end
    n_checks++; if (d2 !== 8'h00) begin n_fail++; $display("FAIL zero_fill_addr5_u2: got %h expected 00", d2); end
    tick;
    n_checks++; if (v0 !== 1'b0)  begin n_fail++; $display("FAIL rd_valid_one_pulse: got %b expected 0", v0); end
  endtask

  task automatic test_byte_lanes;
    wr = 1'b1; addr_w = 7'd3; data_i = 8'h00;
    data32 = 32'hAABBCCDD; be4 = 4'b1111;
    tick;
    data32 = 32'h11223344; be4 = 4'b0101;
    tick;
    wr = 1'b0; be4 = 4'b0000;
    rd = 1'b1; addr_r = 7'd3;
    tick;
    rd = 1'b0;
    n_checks++; if (v1 !== 1'b1)         begin n_fail++; $display("FAIL byte_lane_rd_valid: got %b expected 1", v1); end
    n_checks++; if (d1 !== 32'hAA22CC44) begin n_fail++; $display("FAIL byte_lane_merge: got %h expected aa22cc44", d1); end
  endtask

  task automatic test_rdw;
    wr = 1'b1; addr_w = 7'd7; data_i = 8'h5A; be1 = 1'b1;
    tick;
    data_i = 8'hC3; rd = 1'b1; addr_r = 7'd7;
    tick;
    wr = 1'b0;
    n_checks++; if (d0 !== 8'h5A) begin n_fail++; $display("FAIL rdw_old_data: got %h expected 5a", d0); end
    n_checks++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL rdw_new_data: got %h expected c3", d2); end
    tick;
    n_checks++; if (d0 !== 8'hC3) begin n_fail++; $display("FAIL rdw_old_followup: got %h expected c3", d0); end
    n_checks++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL rdw_new_followup: got %h expected c3", d2); end
    wr = 1'b1; addr_w = 7'd8; data_i = 8'h77; addr_r = 7'd7;
    tick;
    wr = 1'b0; rd = 1'b0;
    n_checks++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL rdw_diff_addr: got %h expected c3", d2); end
  endtask

  task automatic test_streaming;
    logic       exp_v;
    logic [7:0] exp_d;
    wr = 1'b1; be1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_w = 7'(i); data_i = 8'h10 + 8'(i);
      tick;
    end
    wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin rd = 1'b1; addr_r = 7'(i); end
      else rd = 1'b0;
      tick;
      exp_v = (i >= 1 && i <= 4);
      exp_d = 8'h10 + 8'(i - 1);
      n_checks++;
      if (v3 !== exp_v) begin n_fail++; $display("FAIL stream_rd_valid[%0d]: got %b expected %b", i, v3, exp_v); end
      if (exp_v) begin
        n_checks++;
        if (d3 !== exp_d) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, d3, exp_d); end
      end
    end
  endtask

  task automatic test_oe_range;
    wr = 1'b1; addr_w = 7'd9; data_i = 8'h5A;
    tick;
    wr = 1'b0; rd = 1'b1; addr_r = 7'd9; oe = 1'b1;
    tick;
    rd = 1'b0;
    n_checks++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL oe_forces_zero: got %h expected 00", d0); end
    n_checks++; if (v0 !== 1'b1)  begin n_fail++; $display("FAIL oe_rd_valid: got %b expected 1", v0); end
    oe = 1'b0;
    #1;
    n_checks++; if (d0 !== 8'h5A) begin n_fail++; $display("FAIL oe_release: got %h expected 5a", d0); end
    tick;
    n_checks++; if (d0 !== 8'h5A) begin n_fail++; $display("FAIL data_hold: got %h expected 5a", d0); end
    n_checks++; if (v0 !== 1'b0)  begin n_fail++; $display("FAIL hold_rd_valid: got %b expected 0", v0); end
    wr = 1'b1; addr_w = 7'd120; data_i = 8'hEE;
    tick;
    wr = 1'b0; rd = 1'b1; addr_r = 7'd120;
    tick;
    n_checks++; if (v4 !== 1'b1)  begin n_fail++; $display("FAIL oor_rd_valid: got %b expected 1", v4); end
    n_checks++; if (d4 !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %h expected 00", d4); end
    addr_r = 7'd20;
    tick;
    rd = 1'b0;
    n_checks++; if (d4 !== 8'h00) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 00", d4); end
  endtask

  task automatic test_reset_mid_init;
    int cnt;
    int cyc;
    int bad;
    cnt = 0; cyc = 0; bad = 0;
    RST_n = 1'b0;
    tick;
    RST_n = 1'b1;
    for (int i = 0; i < 60; i++) tick;
    RST_n = 1'b0;
    #1;
    n_checks++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL mid_init_busy: got %b expected 1", b0); end
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL mid_init_rd_valid: got %b expected 0", v0); end
    tick; tick;
    RST_n = 1'b1;
    while (b0 === 1'b1 && cyc < 200) begin
      cnt++;
      tick;
      cyc++;
    end
    n_checks++; if (cnt != 128) begin n_fail++; $display("FAIL restart_busy_cycles: got %0d expected 128", cnt); end
    for (int a = 0; a < 128; a++) begin
      rd = 1'b1; addr_r = 7'(a);
      tick;
      if (v0 !== 1'b1 || d0 !== 8'h00) begin
        bad++;
        $display("FAIL refill_word[%0d]: got valid=%b data=%h expected valid=1 data=00", a, v0, d0);
      end
    end
    rd = 1'b0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL refill_all_zero: got %0d bad words expected 0", bad); end
  endtask

  initial begin
    test_reset;
    test_zero_fill;
    test_byte_lanes;
    test_rdw;
    test_streaming;
    test_oe_range;
    test_reset_mid_init;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_block_dp.md
Name: ram_block_dp

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, both on CLK. Successor to the team's fixed 128x8 RAM block.
- Adds byte-lane write enables, selectable read latency and read-during-write mode.
- Adds a hardware zero-fill sequence after reset, with a busy flag.
- Used as a scratch/line buffer between datapath stages; oe gates the read bus without internal tristates.

Parameters:
W, 128, number of words
N, 8, word width in bits; must be a multiple of 8
A_N, 7, address width; requires 2**A_N >= W
BE_N, N/8, number of byte lanes (derived; not to be overridden)
RD_LAT, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (write-first)
INIT_ON_RST, 1, 1 = zero-fill all words after reset; 0 = skip zero-fill, contents undefined

Ports:
CLK  input  1  clock, all state on rising edge
RST_n  input  1  asynchronous active-low reset
wr  input  1  write request
addr_w  input  A_N  write address
data_i  input  N  write data
be  input  BE_N  byte-lane write enables; lane k = data_i[8k+7:8k]
rd  input  1  read request
addr_r  input  A_N  read address
oe  input  1  output disable, active high
data_o  output  N  read data
rd_valid  output  1  one-cycle pulse, data_o holds the requested word
busy  output  1  zero-fill in progress; requests ignored

Behaviour:
- Reset (RST_n low, async):
  - rd_valid=0, read data register=0, read pipeline cleared.
  - busy=INIT_ON_RST; init counter=0.
  - Memory contents are not reset directly.
- FSM states INIT and READY. Reset enters INIT if INIT_ON_RST, else READY.
- INIT:
  - Each cycle writes 0 to M[cnt], then cnt+1.
  - The cycle that writes cnt=W-1 transitions to READY; busy drops on the next edge.
  - busy is high for exactly W cycles after reset release.
  - wr/rd are ignored in INIT; no rd_valid is generated.
  - RST_n asserted mid-INIT restarts at cnt=0.
- READY, write: at an edge with wr=1 and addr_w<W, M[addr_w] lane k <= data_i lane k for each be[k]=1. Lanes with be[k]=0 are unchanged. addr_w>=W: write dropped.
- READY, read:
  - rd=1 at edge T samples addr_r.
  - Data is registered and rd_valid=1 after edge T+RD_LAT-1, i.e. visible in cycle T+RD_LAT.
  - Back-to-back reads give one result per cycle.
  - addr_r>=W returns 0, with rd_valid still asserted.
- Read-during-write, same address, same edge:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (written lanes new, others old).
  - Different addresses are independent.
- data_o: combinational. oe=1 forces data_o=0 regardless of state. oe=0 shows the read data register.
  - rd_valid is not affected by oe.
  - The register holds its last value until the next read completes.
- rd_valid is 0 in every cycle without a completing read.

Decomposition:
- Package ram_pkg:
  - state enum {ST_INIT, ST_READY}
  - RDW_OLD=0, RDW_NEW=1 constants
  - function clog2 for testbench address sizing
- Sub-module ram_init_seq:
  - Contains the INIT/READY FSM and init counter.
  - Outputs busy, init_we, init_addr.
  - The top level muxes the init write ahead of the user write port.
- Memory array and read pipeline stay in ram_block_dp.

Test Plan:
- Zero-fill (W=128): release RST_n -> busy=1 for exactly 128 cycles. wr=1 addr_w=5 during INIT is ignored. After busy=0, rd addr 5 -> data_o=0x00, rd_valid=1 one cycle later.
- Byte lanes (N=32): write 0xAABBCCDD be=4'b1111 to addr 3, then 0x11223344 be=4'b0101 -> read addr 3 returns 0xAA22CC44.
- Read-during-write: M[7]=0x5A, same edge wr 0xC3 to 7 and rd 7. RDW_MODE=0 -> 0x5A; RDW_MODE=1 -> 0xC3. Next read -> 0xC3.
- Latency/streaming: RD_LAT=2, rd on 4 consecutive edges at addr 0..3 holding 0x10..0x13 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd, data 0x10,0x11,0x12,0x13.
- oe gating and out-of-range: read 0x5A with oe=1 -> data_o=0, rd_valid=1. Drop oe -> data_o=0x5A. With W=100, A_N=7: wr to addr 120 leaves memory unchanged, rd 120 -> 0.
- Reset mid-INIT: assert RST_n low at init cycle 60 -> busy stays high. After release, busy is high for a full 128 cycles, and all words read 0.
